lector_destinos: RTL and testbench

Drain-side reader for the two destination FIFOs (D0, D1) at the output of the VC/QoS datapath. It is the counterpart of the write side that pushes words into the Main FIFO. The block pops D0 and D1 under round-robin arbitration and presents one word per cycle to a single sink. It also counts delivered words per destination, optionally checks each word's destination bit, and halts on any FIFO error.

---
 rtl/lector_destinos.sv | 141 ++++++++++++++
 tb/tb_lector_destinos.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lector_destinos.sv
// lector_destinos: drain-side reader for destination FIFOs D0/D1.
// Pops both FIFOs under round-robin arbitration, delivers one word per cycle
// two cycles after the pop, counts delivered words per source FIFO and halts
// on FIFO errors.
// Optional macro DEST_CHECK_EN: compares each captured word's destination bit
// (BW-2) against the FIFO it came from; a mismatch raises error_dest/error_out.
module lector_destinos #(
  parameter int unsigned BW    = 6,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sink_ready,
  input  logic             D0_empty,
  input  logic             D1_empty,
  input  logic             D0_error_output,
  input  logic             D1_error_output,
  input  logic [BW-1:0]    D0_data_out,
  input  logic [BW-1:0]    D1_data_out,
  output logic             D0_rd,
  output logic             D1_rd,
  output logic [BW-1:0]    data_out,
  output logic             valid_out,
  output logic             dest_out,
  output logic [CNT_W-1:0] cnt_D0,
  output logic [CNT_W-1:0] cnt_D1,
  output logic             error_out,
  output logic             error_dest,
  output logic             idle_out,
  output logic             active_out
);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_HOLD, S_ERROR} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t        state;
  state_t        state_nx;
  logic          ptr;
  logic          pending;
  logic          src;
  logic          err_entry;
  logic          pop_ok;
  logic          dest_bad;
  logic [BW-1:0] cap_data;

  // Word arriving from the FIFO popped last cycle.
  assign cap_data = src ? D1_data_out : D0_data_out;

`ifdef DEST_CHECK_EN
  localparam int unsigned DBIT = BW - 2;

  // Destination bit must name the FIFO the word was read from.
  assign dest_bad = pending & (cap_data[DBIT] != src);

  // Sticky mismatch flag, visible in the word's valid_out cycle.
  always_ff @(posedge clk) begin
    if (reset) error_dest <= 1'b0;
    else       error_dest <= error_dest | dest_bad;
  end
`else
  assign dest_bad   = 1'b0;
  assign error_dest = 1'b0;
`endif

  // Entering ERROR also suppresses pops in the same cycle.
  assign err_entry = D0_error_output | D1_error_output | error_dest;
  assign pop_ok    = (state == S_ACTIVE) & enable & sink_ready & ~err_entry;
  assign D0_rd     = pop_ok & ~D0_empty & (~ptr | D1_empty);
  assign D1_rd     = pop_ok & ~D1_empty & (ptr | D0_empty);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    if (state != S_ERROR && err_entry) begin
      state_nx = S_ERROR;
    end else begin
      case (state)
        S_IDLE:   if (enable) state_nx = S_ACTIVE;
        S_ACTIVE: if (!sink_ready || !enable) state_nx = S_HOLD;
        S_HOLD: begin
          if (sink_ready && enable)  state_nx = S_ACTIVE;
          else if (!enable && !pending) state_nx = S_IDLE;
        end
        S_ERROR:  state_nx = S_ERROR;
        default:  state_nx = S_IDLE;
      endcase
    end
  end

  // Registered state indicators.
  always_ff @(posedge clk) begin
    if (reset) begin
      idle_out   <= 1'b1;
      active_out <= 1'b0;
    end else begin
      idle_out   <= (state_nx == S_IDLE);
      active_out <= (state_nx == S_ACTIVE);
    end
  end

  // Arbitration pointer, in-flight tracking, delivery and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr       <= 1'b0;
      pending   <= 1'b0;
      src       <= 1'b0;
      data_out  <= '0;
      valid_out <= 1'b0;
      dest_out  <= 1'b0;
      cnt_D0    <= '0;
      cnt_D1    <= '0;
      error_out <= 1'b0;
    end else begin
      if (D0_rd || D1_rd) begin
        ptr <= D0_rd;
        src <= D1_rd;
      end
      pending   <= D0_rd | D1_rd;
      valid_out <= pending;
      if (pending) begin
        data_out <= cap_data;
        dest_out <= src;
        if (!src) begin
          if (cnt_D0 != CNT_MAX) cnt_D0 <= cnt_D0 + CNT_W'(1);
        end else begin
          if (cnt_D1 != CNT_MAX) cnt_D1 <= cnt_D1 + CNT_W'(1);
        end
      end
      error_out <= error_out | D0_error_output | D1_error_output | dest_bad;
    end
  end

endmodule

// File: tb/tb_lector_destinos.sv
// Bench for lector_destinos: table of per-cycle vectors plus hand-written
// sequences for streaming, saturation, reset, FIFO error and destination bit.
module tb_lector_destinos;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       sink_ready;
  logic       D0_empty;
  logic       D1_empty;
  logic       D0_error_output;
  logic       D1_error_output;
  logic [5:0] D0_data_out;
  logic [5:0] D1_data_out;
  logic       D0_rd;
  logic       D1_rd;
  logic [5:0] data_out;
  logic       valid_out;
  logic       dest_out;
  logic [7:0] cnt_D0;
  logic [7:0] cnt_D1;
  logic       error_out;
  logic       error_dest;
  logic       idle_out;
  logic       active_out;

  int n_checks = 0;
  int n_pass   = 0;

  lector_destinos #(.BW(6), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .sink_ready(sink_ready),
    .D0_empty(D0_empty), .D1_empty(D1_empty),
    .D0_error_output(D0_error_output), .D1_error_output(D1_error_output),
    .D0_data_out(D0_data_out), .D1_data_out(D1_data_out),
    .D0_rd(D0_rd), .D1_rd(D1_rd), .data_out(data_out), .valid_out(valid_out),
    .dest_out(dest_out), .cnt_D0(cnt_D0), .cnt_D1(cnt_D1),
    .error_out(error_out), .error_dest(error_dest),
    .idle_out(idle_out), .active_out(active_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en, sr, e0, e1;
    logic [5:0] d0, d1;
    logic       rd0, rd1, vld;
    logic [5:0] data;
    logic       dest;
    logic [7:0] c0, c1;
    logic       act;
  } vec_t;

  vec_t vt[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    enable = 1'b0; sink_ready = 1'b1;
    D0_empty = 1'b1; D1_empty = 1'b1;
    D0_error_output = 1'b0; D1_error_output = 1'b0;
    D0_data_out = '0; D1_data_out = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " valid"}, 32'(valid_out), 0);
    chk({tag, " data"}, 32'(data_out), 0);
    chk({tag, " dest"}, 32'(dest_out), 0);
    chk({tag, " cnt0"}, 32'(cnt_D0), 0);
    chk({tag, " cnt1"}, 32'(cnt_D1), 0);
    chk({tag, " err"}, 32'(error_out), 0);
    chk({tag, " err_dest"}, 32'(error_dest), 0);
    chk({tag, " idle"}, 32'(idle_out), 1);
    chk({tag, " active"}, 32'(active_out), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_v;
    //            en sr e0 e1 d0     d1     rd0 rd1 v  data   dest c0 c1 act
    vt[0]  = '{1, 1, 0, 0, 6'h00, 6'h00, 0, 0, 0, 6'h00, 0, 0, 0, 0};
    vt[1]  = '{1, 1, 0, 0, 6'h00, 6'h00, 1, 0, 0, 6'h00, 0, 0, 0, 1};
    vt[2]  = '{1, 1, 0, 0, 6'h21, 6'h00, 0, 1, 0, 6'h00, 0, 0, 0, 1};
    vt[3]  = '{1, 1, 0, 1, 6'h00, 6'h3F, 1, 0, 1, 6'h21, 0, 1, 0, 1};
    vt[4]  = '{1, 1, 1, 1, 6'h0C, 6'h00, 0, 0, 1, 6'h3F, 1, 1, 1, 1};
    vt[5]  = '{1, 1, 1, 1, 6'h00, 6'h00, 0, 0, 1, 6'h0C, 0, 2, 1, 1};
    vt[6]  = '{1, 1, 1, 1, 6'h00, 6'h00, 0, 0, 0, 6'h00, 0, 2, 1, 1};
    vt[7]  = '{1, 1, 0, 0, 6'h00, 6'h00, 0, 1, 0, 6'h00, 0, 2, 1, 1};
    vt[8]  = '{1, 1, 0, 0, 6'h00, 6'h11, 1, 0, 0, 6'h00, 0, 2, 1, 1};
    vt[9]  = '{1, 0, 0, 0, 6'h05, 6'h00, 0, 0, 1, 6'h11, 1, 2, 2, 1};
    vt[10] = '{1, 0, 0, 0, 6'h00, 6'h00, 0, 0, 1, 6'h05, 0, 3, 2, 0};
    vt[11] = '{1, 0, 0, 0, 6'h00, 6'h00, 0, 0, 0, 6'h00, 0, 3, 2, 0};
    vt[12] = '{1, 0, 0, 0, 6'h00, 6'h00, 0, 0, 0, 6'h00, 0, 3, 2, 0};
    vt[13] = '{1, 0, 0, 0, 6'h00, 6'h00, 0, 0, 0, 6'h00, 0, 3, 2, 0};
    vt[14] = '{1, 1, 0, 0, 6'h00, 6'h00, 0, 0, 0, 6'h00, 0, 3, 2, 0};
    vt[15] = '{1, 1, 0, 0, 6'h00, 6'h00, 0, 1, 0, 6'h00, 0, 3, 2, 1};
    vt[16] = '{1, 1, 0, 0, 6'h00, 6'h3A, 1, 0, 0, 6'h00, 0, 3, 2, 1};
    vt[17] = '{1, 1, 1, 1, 6'h0A, 6'h00, 0, 0, 1, 6'h3A, 1, 3, 3, 1};
    vt[18] = '{1, 1, 1, 1, 6'h00, 6'h00, 0, 0, 1, 6'h0A, 0, 4, 3, 1};
    vt[19] = '{1, 1, 1, 1, 6'h00, 6'h00, 0, 0, 0, 6'h00, 0, 4, 3, 1};

    // Reset values.
    do_reset();
    @(negedge clk);
    chk_reset_vals("reset");
    chk("reset rd0", 32'(D0_rd), 0);
    chk("reset rd1", 32'(D1_rd), 0);
    tick();

    // Round-robin and sink_ready stall, one vector per cycle.
    for (int k = 0; k < 20; k++) begin
      enable = vt[k].en; sink_ready = vt[k].sr;
      D0_empty = vt[k].e0; D1_empty = vt[k].e1;
      D0_data_out = vt[k].d0; D1_data_out = vt[k].d1;
      @(negedge clk);
      chk($sformatf("vec%0d rd0", k), 32'(D0_rd), 32'(vt[k].rd0));
      chk($sformatf("vec%0d rd1", k), 32'(D1_rd), 32'(vt[k].rd1));
      chk($sformatf("vec%0d valid", k), 32'(valid_out), 32'(vt[k].vld));
      if (vt[k].vld) begin
        chk($sformatf("vec%0d data", k), 32'(data_out), 32'(vt[k].data));
        chk($sformatf("vec%0d dest", k), 32'(dest_out), 32'(vt[k].dest));
      end
      chk($sformatf("vec%0d cnt0", k), 32'(cnt_D0), 32'(vt[k].c0));
      chk($sformatf("vec%0d cnt1", k), 32'(cnt_D1), 32'(vt[k].c1));
      chk($sformatf("vec%0d active", k), 32'(active_out), 32'(vt[k].act));
      tick();
    end

    // Only D1 holds 14 words: pops every cycle, valid two cycles later.
    do_reset();
    enable = 1'b1;
    tick();
    for (int t = 0; t < 18; t++) begin
      D1_empty    = (t >= 14);
      D1_data_out = (t >= 1 && t <= 14) ? 6'(16 + t - 1) : 6'h00;
      exp_v       = (t >= 2 && t <= 15);
      @(negedge clk);
      chk($sformatf("d1only t%0d rd1", t), 32'(D1_rd), 32'(t < 14));
      chk($sformatf("d1only t%0d rd0", t), 32'(D0_rd), 0);
      chk($sformatf("d1only t%0d valid", t), 32'(valid_out), 32'(exp_v));
      if (exp_v) chk($sformatf("d1only t%0d data", t), 32'(data_out), 32'(16 + t - 2));
      tick();
    end
    @(negedge clk);
    chk("d1only cnt1", 32'(cnt_D1), 14);
    chk("d1only cnt0", 32'(cnt_D0), 0);
    tick();

    // Counter saturation after 258 D0 words.
    do_reset();
    enable = 1'b1;
    tick();
    D0_empty = 1'b0; D0_data_out = 6'h01;
    for (int t = 0; t < 258; t++) tick();
    D0_empty = 1'b1;
    tick(); tick(); tick();
    @(negedge clk);
    chk("sat cnt0", 32'(cnt_D0), 255);
    chk("sat cnt1", 32'(cnt_D1), 0);
    tick();

    // Reset mid-stream discards the in-flight words.
    D0_empty = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    chk_reset_vals("midreset");
    chk("midreset rd0", 32'(D0_rd), 0);
    tick();
    @(negedge clk);
    chk("midreset valid+1", 32'(valid_out), 0);
    tick();

    // FIFO error while active.
    do_reset();
    enable = 1'b1;
    tick();
    D0_empty = 1'b0; D1_empty = 1'b0;
    @(negedge clk);
    chk("err t0 rd0", 32'(D0_rd), 1);
    tick();
    D0_data_out = 6'h02;
    @(negedge clk);
    chk("err t1 rd1", 32'(D1_rd), 1);
    tick();
    D0_data_out = 6'h00; D1_data_out = 6'h13; D0_error_output = 1'b1;
    @(negedge clk);
    chk("err t2 rd0", 32'(D0_rd), 0);
    chk("err t2 rd1", 32'(D1_rd), 0);
    chk("err t2 data", 32'(data_out), 32'h02);
    tick();
    D0_error_output = 1'b0; D1_data_out = 6'h00;
    @(negedge clk);
    chk("err t3 error_out", 32'(error_out), 1);
    chk("err t3 valid", 32'(valid_out), 1);
    chk("err t3 data", 32'(data_out), 32'h13);
    chk("err t3 dest", 32'(dest_out), 1);
    chk("err t3 active", 32'(active_out), 0);
    tick();
    for (int t = 0; t < 6; t++) begin
      enable = t[0];
      @(negedge clk);
      chk($sformatf("err hold%0d rd", t), 32'({D0_rd, D1_rd}), 0);
      chk($sformatf("err hold%0d error_out", t), 32'(error_out), 1);
      chk($sformatf("err hold%0d idle", t), 32'(idle_out), 0);
      tick();
    end

    // Word 11_0101 read from D0 (destination bit says D1).
    do_reset();
    enable = 1'b1;
    tick();
    D0_empty = 1'b0;
    tick();
    D0_empty = 1'b1; D0_data_out = 6'h35;
    tick();
    D0_data_out = 6'h00;
    @(negedge clk);
    chk("dest valid", 32'(valid_out), 1);
    chk("dest data", 32'(data_out), 32'h35);
    chk("dest cnt0", 32'(cnt_D0), 1);
`ifdef DEST_CHECK_EN
    chk("dest error_dest", 32'(error_dest), 1);
    chk("dest error_out", 32'(error_out), 1);
`else
    chk("dest error_dest", 32'(error_dest), 0);
    chk("dest error_out", 32'(error_out), 0);
`endif
    tick();
    // Dropping enable walks back to IDLE through HOLD when nothing is in flight.
    enable = 1'b0;
    tick();
    tick();
    @(negedge clk);
`ifdef DEST_CHECK_EN
    chk("dest idle after disable", 32'(idle_out), 0);
`else
    chk("dest idle after disable", 32'(idle_out), 1);
`endif
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
